// File: rtl/serial_pkg.sv
// Shared types and constants for the serial sync-framed transmit path.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
    } tx_state_t;

    // Frame sync pattern, sent MSB first; the downstream detector keys off the same value.
    localparam logic [2:0] SYNC_PAT = 3'b101;
    localparam int         SYNC_LEN = 3;

    // Sync bit sent at position idx (0 = first on the wire).
    function automatic logic sync_bit(input logic [1:0] idx);
        return SYNC_PAT[2'(SYNC_LEN - 1) - idx];
    endfunction

endpackage

// File: rtl/serial_sync_tx.sv
// Serial frame transmitter: "101" sync followed by the data word, MSB first.
module serial_sync_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned      CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [1:0]       SYNC_LAST = 2'(SYNC_LEN - 1);

    tx_state_t        state, state_d;
    logic [1:0]       sync_cnt, sync_cnt_d;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             sout_d;
    logic             frame_done_d;
    logic             last_bit;
    logic             accept;

    // Handshake decodes from registered state only.
    assign last_bit = (state == DATA) && (bit_cnt == LAST_BIT);
    assign in_ready = (state == IDLE) || last_bit;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // State, counters, shift register and line output advance together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sync_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sout       <= IDLE_BIT;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            sync_cnt   <= sync_cnt_d;
            bit_cnt    <= bit_cnt_d;
            shreg      <= shreg_d;
            sout       <= sout_d;
            frame_done <= frame_done_d;
        end
    end

    // Next state plus the value sout will show in that next state.
    always_comb begin
        state_d      = state;
        sync_cnt_d   = sync_cnt;
        bit_cnt_d    = bit_cnt;
        shreg_d      = shreg;
        sout_d       = sout;
        frame_done_d = 1'b0;
        unique case (state)
            IDLE: begin
                sout_d = IDLE_BIT;
                if (accept) begin
                    state_d    = SYNC;
                    sync_cnt_d = 2'd0;
                    shreg_d    = in_data;
                    sout_d     = sync_bit(2'd0);
                end
            end
            SYNC: begin
                if (sync_cnt == SYNC_LAST) begin
                    state_d      = DATA;
                    bit_cnt_d    = '0;
                    sout_d       = shreg[WIDTH-1];
                    shreg_d      = shreg << 1;
                    frame_done_d = (LAST_BIT == '0);
                end else begin
                    sync_cnt_d = sync_cnt + 2'd1;
                    sout_d     = sync_bit(sync_cnt + 2'd1);
                end
            end
            DATA: begin
                if (last_bit) begin
                    if (accept) begin
                        state_d    = SYNC;
                        sync_cnt_d = 2'd0;
                        shreg_d    = in_data;
                        sout_d     = sync_bit(2'd0);
                    end else begin
                        state_d = IDLE;
                        sout_d  = IDLE_BIT;
                    end
                end else begin
                    bit_cnt_d    = bit_cnt + CNT_W'(1);
                    sout_d       = shreg[WIDTH-1];
                    shreg_d      = shreg << 1;
                    frame_done_d = ((bit_cnt + CNT_W'(1)) == LAST_BIT);
                end
            end
            default: begin
                state_d = IDLE;
                sout_d  = IDLE_BIT;
            end
        endcase
    end

endmodule
